// File: rtl/store_unit_pkg.sv
// Shared constants for the store unit: access-size codes, FSM encoding and
// small decode helpers used by both the FSM and the lane aligner.
package store_unit_pkg;

    localparam int MEM_TYPE_LEN = 3;

    localparam logic [MEM_TYPE_LEN-1:0] MEM_B = 3'd0;
    localparam logic [MEM_TYPE_LEN-1:0] MEM_H = 3'd1;
    localparam logic [MEM_TYPE_LEN-1:0] MEM_W = 3'd2;
    localparam logic [MEM_TYPE_LEN-1:0] MEM_D = 3'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2,
        RESP  = 2'd3
    } su_state_e;

    // Access size in bytes; codes 4..7 are undefined and decode as one byte.
    function automatic logic [3:0] size_bytes(input logic [MEM_TYPE_LEN-1:0] t);
        case (t)
            MEM_H:   return 4'd2;
            MEM_W:   return 4'd4;
            MEM_D:   return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

    function automatic logic type_legal(input logic [MEM_TYPE_LEN-1:0] t, input int xlen);
        return (t == MEM_B) || (t == MEM_H) || (t == MEM_W) || ((t == MEM_D) && (xlen == 64));
    endfunction

    function automatic logic [63:0] size_mask(input logic [3:0] size);
        return (size == 4'd8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << {size, 3'b000}) - 64'd1);
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Request/response and memory write-beat signals of the store unit.
// slave is the store unit's view, master the view of the core and memory.
interface store_unit_if
    import store_unit_pkg::*;
#(
    parameter int XLEN = 32
) ();
    logic                    req_valid;
    logic                    req_ready;
    logic [XLEN-1:0]         req_addr;
    logic [XLEN-1:0]         req_data;
    logic [MEM_TYPE_LEN-1:0] req_type;
    logic                    done;
    logic                    fault;
    logic                    mem_valid;
    logic                    mem_ready;
    logic [XLEN-1:0]         mem_addr;
    logic [XLEN-1:0]         mem_wdata;
    logic [XLEN/8-1:0]       mem_wstrb;

    modport slave (
        input  req_valid, req_addr, req_data, req_type, mem_ready,
        output req_ready, done, fault, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output req_valid, req_addr, req_data, req_type, mem_ready,
        input  req_ready, done, fault, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/store_unit_align.sv
// store_align: purely combinational size masking, lane shifting and strobe
// generation for both write beats of a store.
module store_align
    import store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]         addr_i,
    input  logic [XLEN-1:0]         data_i,
    input  logic [MEM_TYPE_LEN-1:0] type_i,
    output logic                    legal_o,
    output logic                    crossing_o,
    output logic [XLEN-1:0]         data_masked_o,
    output logic [XLEN-1:0]         b1_addr_o,
    output logic [XLEN-1:0]         b1_wdata_o,
    output logic [XLEN/8-1:0]       b1_wstrb_o,
    output logic [XLEN-1:0]         b2_addr_o,
    output logic [XLEN-1:0]         b2_wdata_o,
    output logic [XLEN/8-1:0]       b2_wstrb_o
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    logic [OFFW-1:0] off;
    logic [3:0]      size;
    logic [4:0]      end_byte;
    logic [7:0]      sh2;

    always_comb begin
        off           = addr_i[OFFW-1:0];
        size          = size_bytes(type_i);
        legal_o       = type_legal(type_i, XLEN);
        data_masked_o = data_i & XLEN'(size_mask(size));
        end_byte      = 5'(off) + 5'(size);
        crossing_o    = end_byte > 5'(NB);

        b1_addr_o  = {addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
        b1_wdata_o = data_masked_o << {off, 3'b000};
        b1_wstrb_o = NB'(((16'd1 << size) - 16'd1) << off);

        // Beat 2 carries the bytes that spilled past the top lane of beat 1.
        b2_addr_o  = b1_addr_o + XLEN'(NB);
        sh2        = 8'((NB - int'(off)) * 8);
        b2_wdata_o = crossing_o ? (data_masked_o >> sh2) : '0;
        b2_wstrb_o = crossing_o ? NB'((16'd1 << (end_byte - 5'(NB))) - 16'd1) : '0;
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts one store, issues one or two aligned write beats and
// reports completion (done) or an illegal request (fault) for one cycle.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    store_unit_if.slave bus
);
    su_state_e               state_q, state_d;
    logic [XLEN-1:0]         addr_q, addr_d;
    logic [XLEN-1:0]         data_q, data_d;
    logic [MEM_TYPE_LEN-1:0] type_q, type_d;
    logic                    fault_q, fault_d;

    logic                    idle;
    logic                    al_legal, al_crossing;
    logic [XLEN-1:0]         al_data_masked;
    logic [XLEN-1:0]         b1_addr, b1_wdata, b2_addr, b2_wdata;
    logic [XLEN/8-1:0]       b1_wstrb, b2_wstrb;

    assign idle = (state_q == IDLE);

    // One aligner serves both decode at acceptance (live request) and beat
    // generation afterwards (latched request).
    store_align #(.XLEN(XLEN)) u_align (
        .addr_i        (idle ? bus.req_addr : addr_q),
        .data_i        (idle ? bus.req_data : data_q),
        .type_i        (idle ? bus.req_type : type_q),
        .legal_o       (al_legal),
        .crossing_o    (al_crossing),
        .data_masked_o (al_data_masked),
        .b1_addr_o     (b1_addr),
        .b1_wdata_o    (b1_wdata),
        .b1_wstrb_o    (b1_wstrb),
        .b2_addr_o     (b2_addr),
        .b2_wdata_o    (b2_wdata),
        .b2_wstrb_o    (b2_wstrb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            type_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            type_q  <= type_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        type_d  = type_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d = bus.req_addr;
                    data_d = al_data_masked;
                    type_d = bus.req_type;
                    if (!al_legal || (al_crossing && !ALLOW_MISALIGNED)) begin
                        fault_d = 1'b1;
                        state_d = RESP;
                    end else begin
                        fault_d = 1'b0;
                        state_d = BEAT1;
                    end
                end
            end
            BEAT1:   if (bus.mem_ready) state_d = al_crossing ? BEAT2 : RESP;
            BEAT2:   if (bus.mem_ready) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = idle;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        bus.done      = 1'b0;
        bus.fault     = 1'b0;
        case (state_q)
            BEAT1: begin
                bus.mem_valid = 1'b1;
                bus.mem_addr  = b1_addr;
                bus.mem_wdata = b1_wdata;
                bus.mem_wstrb = b1_wstrb;
            end
            BEAT2: begin
                bus.mem_valid = 1'b1;
                bus.mem_addr  = b2_addr;
                bus.mem_wdata = b2_wdata;
                bus.mem_wstrb = b2_wstrb;
            end
            RESP: begin
                bus.done  = !fault_q;
                bus.fault = fault_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_store_unit.sv
// Randomised and directed bench for store_unit (XLEN=32): a byte-level model
// predicts beats, done/fault timing and ready, checked every cycle.
module tb_store_unit;
    import store_unit_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_unit_if #(.XLEN(32)) bus0 ();
    store_unit_if #(.XLEN(32)) bus1 ();

    store_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    store_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    beat_t exp_q[$];
    beat_t obs_log[$];
    bit    pending = 1'b0;
    bit    exp_legal = 1'b0;
    bit    exp_valid;
    int    acc_cyc = 0;
    int    resp_cyc = -1;
    int    last_latency = -1;
    bit    last_fault = 1'b0;
    bit    rand_mode = 1'b0;
    bit    forced_ready = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the DUT (t=%0t)", name, $time);
    endtask

    // Byte-by-byte reference: each stored byte lands at addr+i in the lane of
    // its own word; words other than the first form the second beat.
    function automatic bit model_push(input logic [31:0] a, input logic [31:0] d,
                                      input logic [2:0] t, input bit am);
        int          size;
        beat_t       b[2];
        logic [31:0] base;
        logic [31:0] ba;
        logic [31:0] w;
        int          lane;
        int          j;
        int          nbeats;
        case (t)
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            default: return 1'b0;
        endcase
        b[0] = '0;
        b[1] = '0;
        base = a & 32'hFFFF_FFFC;
        nbeats = 1;
        for (int i = 0; i < size; i++) begin
            ba   = a + 32'(i);
            w    = ba & 32'hFFFF_FFFC;
            lane = int'(ba[1:0]);
            j    = (w == base) ? 0 : 1;
            if (j == 1) nbeats = 2;
            b[j].addr = w;
            b[j].wdata[8*lane +: 8] = d[8*i +: 8];
            b[j].wstrb[lane] = 1'b1;
        end
        if (nbeats == 2 && !am) return 1'b0;
        for (int k = 0; k < nbeats; k++) exp_q.push_back(b[k]);
        return 1'b1;
    endfunction

    // Per-cycle compare of dut0 against the model.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            pending = 1'b0;
            exp_q.delete();
            resp_cyc = -1;
        end else begin
            chk("req_ready", 64'(bus0.req_ready), 64'(!pending));
            exp_valid = pending && (exp_q.size() > 0) && (cyc > acc_cyc);
            chk("mem_valid", 64'(bus0.mem_valid), 64'(exp_valid));
            if (bus0.mem_valid) begin
                if (exp_q.size() > 0) begin
                    chk("mem_addr", 64'(bus0.mem_addr), 64'(exp_q[0].addr));
                    chk("mem_wdata", 64'(bus0.mem_wdata), 64'(exp_q[0].wdata));
                    chk("mem_wstrb", 64'(bus0.mem_wstrb), 64'(exp_q[0].wstrb));
                    if (bus0.mem_ready) begin
                        obs_log.push_back({bus0.mem_addr, bus0.mem_wdata, bus0.mem_wstrb});
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) resp_cyc = cyc + 1;
                    end
                end
            end else begin
                chk("idle mem_addr", 64'(bus0.mem_addr), 64'd0);
                chk("idle mem_wdata", 64'(bus0.mem_wdata), 64'd0);
                chk("idle mem_wstrb", 64'(bus0.mem_wstrb), 64'd0);
            end
            chk("done", 64'(bus0.done), 64'(pending && exp_legal && cyc == resp_cyc));
            chk("fault", 64'(bus0.fault), 64'(pending && !exp_legal && cyc == resp_cyc));
            if (pending && cyc == resp_cyc) begin
                pending      = 1'b0;
                last_latency = cyc - acc_cyc;
                last_fault   = !exp_legal;
            end
            if (bus0.req_valid && bus0.req_ready) begin
                pending   = 1'b1;
                acc_cyc   = cyc;
                exp_legal = model_push(bus0.req_addr, bus0.req_data, bus0.req_type, 1'b1);
                resp_cyc  = exp_legal ? -1 : cyc + 1;
            end
        end
    end

    initial begin
        bus0.mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus0.mem_ready = rand_mode ? ($urandom_range(0, 3) != 0) : forced_ready;
        end
    end

    // Issue one store on dut0 and wait for it to finish; mem_ready is held low
    // for the first 'stall' cycles of beat 1 when not in random mode.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t, input int stall);
        int n;
        int k;
        n = 0;
        while (!bus0.req_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) timeout_fail("req_ready wait");
        bus0.req_valid = 1'b1;
        bus0.req_addr  = a;
        bus0.req_data  = d;
        bus0.req_type  = t;
        forced_ready   = (stall == 0);
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        bus0.req_addr  = $urandom;
        bus0.req_data  = $urandom;
        bus0.req_type  = 3'($urandom_range(0, 7));
        n = 0;
        k = 1;
        while (pending && n < 200) begin
            if (k == stall + 1) forced_ready = 1'b1;
            @(posedge clk); #1; n++; k++;
        end
        forced_ready = 1'b1;
        if (n >= 200) timeout_fail("store completion");
    endtask

    // Directed store on dut1 (misaligned stores fault); checks four cycles.
    task automatic issue1(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t, input bit exp_fault);
        bus1.req_valid = 1'b1;
        bus1.req_addr  = a;
        bus1.req_data  = d;
        bus1.req_type  = t;
        @(negedge clk);
        chk("dut1 req_ready", 64'(bus1.req_ready), 64'd1);
        @(posedge clk); #1;
        bus1.req_valid = 1'b0;
        bus1.req_addr  = $urandom;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (exp_fault) begin
                chk("dut1 mem_valid", 64'(bus1.mem_valid), 64'd0);
                chk("dut1 fault", 64'(bus1.fault), 64'(k == 1));
                chk("dut1 done", 64'(bus1.done), 64'd0);
            end else begin
                chk("dut1 mem_valid", 64'(bus1.mem_valid), 64'(k == 1));
                chk("dut1 done", 64'(bus1.done), 64'(k == 2));
                chk("dut1 fault", 64'(bus1.fault), 64'd0);
                if (k == 1) begin
                    chk("dut1 mem_addr", 64'(bus1.mem_addr), 64'h104);
                    chk("dut1 mem_wdata", 64'(bus1.mem_wdata), 64'(d));
                    chk("dut1 mem_wstrb", 64'(bus1.mem_wstrb), 64'hF);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_beat(input string name, input int idx, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        if (obs_log.size() > idx) begin
            chk({name, " addr"}, 64'(obs_log[idx].addr), 64'(a));
            chk({name, " wdata"}, 64'(obs_log[idx].wdata), 64'(d));
            chk({name, " wstrb"}, 64'(obs_log[idx].wstrb), 64'(s));
        end else begin
            timeout_fail({name, " missing beat"});
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [2:0]  rt;
        int          r;
        bus0.req_valid = 1'b0; bus0.req_addr = '0; bus0.req_data = '0; bus0.req_type = '0;
        bus1.req_valid = 1'b0; bus1.req_addr = '0; bus1.req_data = '0; bus1.req_type = '0;
        bus1.mem_ready = 1'b1;

        #2;
        chk("reset req_ready", 64'(bus0.req_ready), 64'd1);
        chk("reset mem_valid", 64'(bus0.mem_valid), 64'd0);
        chk("reset done", 64'(bus0.done), 64'd0);
        chk("reset fault", 64'(bus0.fault), 64'd0);
        chk("reset mem_addr", 64'(bus0.mem_addr), 64'd0);
        chk("reset mem_wdata", 64'(bus0.mem_wdata), 64'd0);
        chk("reset mem_wstrb", 64'(bus0.mem_wstrb), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency is counted in cycles after the acceptance cycle.
        obs_log.delete();
        issue(32'h103, 32'h1234_5678, MEM_B, 0);
        chk("sb beats", 64'(obs_log.size()), 64'd1);
        chk_beat("sb b1", 0, 32'h100, 32'h7800_0000, 4'b1000);
        chk("sb latency", 64'(last_latency), 64'd2);

        obs_log.delete();
        issue(32'h102, 32'hAABB_CCDD, MEM_W, 0);
        chk_beat("sw b1", 0, 32'h100, 32'hCCDD_0000, 4'b1100);
        chk_beat("sw b2", 1, 32'h104, 32'h0000_AABB, 4'b0011);
        chk("sw latency", 64'(last_latency), 64'd3);

        obs_log.delete();
        issue(32'h103, 32'hFFFF_BEEF, MEM_H, 2);
        chk_beat("sh b1", 0, 32'h100, 32'hEF00_0000, 4'b1000);
        chk_beat("sh b2", 1, 32'h104, 32'h0000_00BE, 4'b0001);
        chk("sh latency", 64'(last_latency), 64'd5);

        obs_log.delete();
        issue(32'h100, 32'h1111_2222, MEM_D, 0);
        chk("sd beats", 64'(obs_log.size()), 64'd0);
        chk("sd fault", 64'(last_fault), 64'd1);
        chk("sd latency", 64'(last_latency), 64'd1);

        obs_log.delete();
        issue(32'h200, 32'h1234_5678, 3'd5, 0);
        chk("undef fault", 64'(last_fault), 64'd1);

        obs_log.delete();
        issue(32'hFFFF_FFFE, 32'h1122_3344, MEM_W, 0);
        chk_beat("wrap b1", 0, 32'hFFFF_FFFC, 32'h3344_0000, 4'b1100);
        chk_beat("wrap b2", 1, 32'h0000_0000, 32'h0000_1122, 4'b0011);

        issue1(32'h101, 32'hDEAD_BEEF, MEM_W, 1'b1);
        issue1(32'h100, 32'hDEAD_BEEF, MEM_D, 1'b1);
        issue1(32'h104, 32'hCAFE_F00D, MEM_W, 1'b0);

        // Reset while beat 2 is on the bus.
        forced_ready = 1'b1;
        bus0.req_valid = 1'b1;
        bus0.req_addr  = 32'h0FE;
        bus0.req_data  = 32'hCAFE_F00D;
        bus0.req_type  = MEM_W;
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre-reset beat2 valid", 64'(bus0.mem_valid), 64'd1);
        chk("pre-reset beat2 addr", 64'(bus0.mem_addr), 64'h100);
        rst_n = 1'b0;
        #1;
        chk("async reset mem_valid", 64'(bus0.mem_valid), 64'd0);
        chk("async reset mem_addr", 64'(bus0.mem_addr), 64'd0);
        chk("async reset mem_wdata", 64'(bus0.mem_wdata), 64'd0);
        chk("async reset mem_wstrb", 64'(bus0.mem_wstrb), 64'd0);
        chk("async reset req_ready", 64'(bus0.req_ready), 64'd1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("reset done", 64'(bus0.done), 64'd0);
            chk("reset fault", 64'(bus0.fault), 64'd0);
        end
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        obs_log.delete();
        issue(32'h201, 32'h0000_005A, MEM_B, 0);
        chk_beat("post-reset sb", 0, 32'h200, 32'h0000_5A00, 4'b0010);
        chk("post-reset latency", 64'(last_latency), 64'd2);

        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            ra = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7))) : $urandom;
            r  = $urandom_range(0, 9);
            rt = (r < 3) ? MEM_B : (r < 6) ? MEM_H : (r < 9) ? MEM_W : 3'($urandom_range(3, 7));
            issue(ra, $urandom, rt, 0);
        end
        rand_mode = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule
